ingress_pkt_fifo: RTL and testbench

Store-and-forward packet buffer placed directly upstream of the frequency-absorb pipeline's `s_axis` input, which is always ready and has no way to stall a packet. The block accepts the raw ingress AXI-Stream and holds each packet until its last beat has arrived. Only then does it release the packet to the pipeline, as a contiguous burst with no idle cycles inside it. Packets that do not fit are dropped whole and counted, so partial packets never reach the parser.

---
 rtl/ingress_pkt_fifo_if.sv | 15 +
 rtl/ingress_pkt_fifo.sv | 120 ++++++++++++
 tb/tb_ingress_pkt_fifo.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ingress_pkt_fifo_if.sv
// AXI-Stream bundle used on both sides of the ingress packet buffer.
interface ingress_pkt_fifo_if #(
    parameter int DATA_W = 256,
    parameter int USER_W = 128
);
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic [USER_W-1:0]   tuser;
    logic                tvalid;
    logic                tready;
    logic                tlast;

    modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/ingress_pkt_fifo.sv
// Store-and-forward ingress buffer: releases only whole packets, drops packets
// that do not fit, and streams committed packets out without gaps.
module ingress_pkt_fifo #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int ADDR_W               = 6
) (
    input  logic                     axis_aclk,
    input  logic                     axis_reset,
    ingress_pkt_fifo_if.slave        s_axis,
    ingress_pkt_fifo_if.master       m_axis,
    output logic [31:0]              stat_pkt_cnt,
    output logic [31:0]              stat_drop_cnt,
    output logic [ADDR_W:0]          fill_level
);
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int KEEP_W = C_S_AXIS_DATA_WIDTH / 8;
    localparam logic [ADDR_W:0] FULL_LVL = {1'b1, {ADDR_W{1'b0}}};

    typedef struct packed {
        logic                            last;
        logic [C_S_AXIS_TUSER_WIDTH-1:0] user;
        logic [KEEP_W-1:0]               keep;
        logic [C_S_AXIS_DATA_WIDTH-1:0]  data;
    } beat_t;

    typedef enum logic [1:0] {WR_IDLE, WR_PKT, WR_DROP} wr_state_t;

    beat_t       mem [DEPTH];
    beat_t       in_beat, out_q;
    logic        out_vld;
    wr_state_t   state, state_nxt;
    logic [ADDR_W:0] wr_ptr, commit_ptr, rd_ptr;
    logic [ADDR_W:0] wr_ptr_nxt, commit_nxt;
    logic        wr_en, pkt_inc, drop_inc, full, have, load;

    assign s_axis.tready = 1'b1;
    assign in_beat = {s_axis.tlast, s_axis.tuser, s_axis.tkeep, s_axis.tdata};

    // Full uses registered pointers only; a same-cycle read frees space next cycle.
    assign fill_level = wr_ptr - rd_ptr;
    assign full       = (fill_level == FULL_LVL);

    always_comb begin
        state_nxt  = state;
        wr_en      = 1'b0;
        wr_ptr_nxt = wr_ptr;
        commit_nxt = commit_ptr;
        pkt_inc    = 1'b0;
        drop_inc   = 1'b0;
        if (s_axis.tvalid) begin
            case (state)
                WR_IDLE, WR_PKT: begin
                    if (full) begin
                        // Roll back the partial packet; count the drop only once.
                        wr_ptr_nxt = commit_ptr;
                        drop_inc   = 1'b1;
                        state_nxt  = s_axis.tlast ? WR_IDLE : WR_DROP;
                    end else begin
                        wr_en      = 1'b1;
                        wr_ptr_nxt = wr_ptr + 1'b1;
                        if (s_axis.tlast) begin
                            commit_nxt = wr_ptr + 1'b1;
                            pkt_inc    = 1'b1;
                            state_nxt  = WR_IDLE;
                        end else begin
                            state_nxt  = WR_PKT;
                        end
                    end
                end
                WR_DROP: if (s_axis.tlast) state_nxt = WR_IDLE;
                default: state_nxt = WR_IDLE;
            endcase
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            state         <= WR_IDLE;
            wr_ptr        <= '0;
            commit_ptr    <= '0;
            stat_pkt_cnt  <= '0;
            stat_drop_cnt <= '0;
        end else begin
            state         <= state_nxt;
            wr_ptr        <= wr_ptr_nxt;
            commit_ptr    <= commit_nxt;
            stat_pkt_cnt  <= stat_pkt_cnt + {31'd0, pkt_inc};
            stat_drop_cnt <= stat_drop_cnt + {31'd0, drop_inc};
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (wr_en) mem[wr_ptr[ADDR_W-1:0]] <= in_beat;
    end

    // Read side only ever sees whole packets since commit_ptr moves on tlast.
    assign have = (rd_ptr != commit_ptr);
    assign load = (!out_vld || m_axis.tready) && have;

    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            rd_ptr  <= '0;
            out_q   <= '0;
            out_vld <= 1'b0;
        end else if (load) begin
            out_q   <= mem[rd_ptr[ADDR_W-1:0]];
            rd_ptr  <= rd_ptr + 1'b1;
            out_vld <= 1'b1;
        end else if (m_axis.tready) begin
            out_vld <= 1'b0;
        end
    end

    assign m_axis.tvalid = out_vld;
    assign m_axis.tdata  = out_q.data;
    assign m_axis.tkeep  = out_q.keep;
    assign m_axis.tuser  = out_q.user;
    assign m_axis.tlast  = out_q.last;
endmodule

// File: tb/tb_ingress_pkt_fifo.sv
// Directed bench for ingress_pkt_fifo: packet table plus hand-written corner sequences.
module tb_ingress_pkt_fifo;
    localparam int DW = 256;
    localparam int UW = 128;
    localparam int KW = DW / 8;
    localparam int AW = 6;

    typedef struct packed {
        logic          last;
        logic [UW-1:0] user;
        logic [KW-1:0] keep;
        logic [DW-1:0] data;
    } tb_beat_t;

    typedef struct {
        logic [7:0] tag;
        int         len;
        int         gap;
        bit         kept;
        int         exp_pkt;
        int         exp_drop;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pkt_cnt, drop_cnt;
    logic [AW:0] fill;

    ingress_pkt_fifo_if #(.DATA_W(DW), .USER_W(UW)) s_if ();
    ingress_pkt_fifo_if #(.DATA_W(DW), .USER_W(UW)) m_if ();

    ingress_pkt_fifo #(
        .C_S_AXIS_DATA_WIDTH (DW),
        .C_S_AXIS_TUSER_WIDTH(UW),
        .ADDR_W              (AW)
    ) dut (
        .axis_aclk    (clk),
        .axis_reset   (rst),
        .s_axis       (s_if.slave),
        .m_axis       (m_if.master),
        .stat_pkt_cnt (pkt_cnt),
        .stat_drop_cnt(drop_cnt),
        .fill_level   (fill)
    );

    always #5 clk = ~clk;

    int       checks = 0;
    int       passes = 0;
    tb_beat_t rx[$];
    tb_beat_t exp_q[$];
    bit       stall_chk = 1'b0;
    bit       toggle_en = 1'b0;
    bit       prev_stall = 1'b0;
    tb_beat_t prev_beat;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
        checks++;
        if (act === want) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, want);
    endtask

    function automatic tb_beat_t mk(input logic [7:0] tag, input int idx, input bit last);
        tb_beat_t b;
        b.data = {8{tag, 8'(idx), 16'hC0DE}};
        b.keep = last ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        b.user = {56'd0, 8'(idx), 56'd0, tag};
        b.last = last;
        return b;
    endfunction

    function automatic tb_beat_t cur_out();
        return {m_if.tlast, m_if.tuser, m_if.tkeep, m_if.tdata};
    endfunction

    // Handshake capture and stall-stability monitor.
    always @(negedge clk) begin
        if (!rst && m_if.tvalid && m_if.tready) rx.push_back(cur_out());
        if (stall_chk && prev_stall)
            chk("stall_hold", {127'd0, (m_if.tvalid === 1'b1) && (cur_out() === prev_beat)}, 128'd1);
        prev_stall = m_if.tvalid && !m_if.tready;
        prev_beat  = cur_out();
    end

    always @(posedge clk) if (toggle_en) begin #1; m_if.tready = !m_if.tready; end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic drive(input tb_beat_t b);
        s_if.tvalid = 1'b1;
        s_if.tdata  = b.data;
        s_if.tkeep  = b.keep;
        s_if.tuser  = b.user;
        s_if.tlast  = b.last;
    endtask

    task automatic send_pkt(input logic [7:0] tag, input int len, input int gap, input bit kept);
        for (int i = 0; i < len; i++) begin
            tb_beat_t b;
            b = mk(tag, i, i == len - 1);
            drive(b);
            if (kept) exp_q.push_back(b);
            tick();
            s_if.tvalid = 1'b0;
            repeat (gap) tick();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_if.tvalid = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        rx.delete();
        exp_q.delete();
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((rx.size() < exp_q.size() || m_if.tvalid) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) chk({name, "_timeout"}, 128'(n), 128'(budget - 1));
    endtask

    task automatic cmp_rx(input string name);
        int mism = 0;
        int n = (rx.size() < exp_q.size()) ? rx.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (rx[i] !== exp_q[i]) mism++;
        chk({name, "_beats"}, 128'(rx.size()), 128'(exp_q.size()));
        chk({name, "_data"}, 128'(mism), 128'd0);
    endtask

    vec_t vecs[6];

    initial begin
        int q;
        vecs[0] = '{tag: 8'h11, len: 1,  gap: 0, kept: 1'b1, exp_pkt: 1, exp_drop: 0};
        vecs[1] = '{tag: 8'h22, len: 5,  gap: 1, kept: 1'b1, exp_pkt: 2, exp_drop: 0};
        vecs[2] = '{tag: 8'h33, len: 64, gap: 0, kept: 1'b1, exp_pkt: 3, exp_drop: 0};
        vecs[3] = '{tag: 8'h44, len: 65, gap: 0, kept: 1'b0, exp_pkt: 3, exp_drop: 1};
        vecs[4] = '{tag: 8'h55, len: 2,  gap: 2, kept: 1'b1, exp_pkt: 4, exp_drop: 1};
        vecs[5] = '{tag: 8'h66, len: 3,  gap: 0, kept: 1'b1, exp_pkt: 5, exp_drop: 1};

        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tuser = '0; s_if.tlast = 1'b0;
        m_if.tready = 1'b1;
        rst = 1'b1;
        repeat (2) tick();
        chk("rst_tready", 128'(s_if.tready), 128'd1);
        chk("rst_tvalid", 128'(m_if.tvalid), 128'd0);
        chk("rst_tdata",  128'(m_if.tdata[127:0]), 128'd0);
        chk("rst_pkt",    128'(pkt_cnt), 128'd0);
        chk("rst_drop",   128'(drop_cnt), 128'd0);
        chk("rst_fill",   128'(fill), 128'd0);
        rst = 1'b0;

        // Packet table, tready held high.
        for (int v = 0; v < 6; v++) begin
            send_pkt(vecs[v].tag, vecs[v].len, vecs[v].gap, vecs[v].kept);
            drain("vec", 200);
            chk($sformatf("vec%0d_pkt", v),  128'(pkt_cnt),  128'(vecs[v].exp_pkt));
            chk($sformatf("vec%0d_drop", v), 128'(drop_cnt), 128'(vecs[v].exp_drop));
        end
        cmp_rx("vec");

        // Single-beat latency.
        do_reset();
        drive(mk(8'hA5, 0, 1'b1));
        tick();
        s_if.tvalid = 1'b0;
        chk("lat_k_tvalid", 128'(m_if.tvalid), 128'd0);
        chk("lat_k_pkt", 128'(pkt_cnt), 128'd1);
        tick();
        chk("lat_k1_tvalid", 128'(m_if.tvalid), 128'd1);
        chk("lat_k1_tlast", 128'(m_if.tlast), 128'd1);
        chk("lat_k1_tuser", m_if.tuser, 128'hA5);
        tick();
        chk("lat_k2_tvalid", 128'(m_if.tvalid), 128'd0);

        // Store-and-forward with gaps between beats.
        do_reset();
        q = 0;
        for (int i = 0; i < 3; i++) begin
            drive(mk(8'h3C, i, 1'b0));
            tick();
            s_if.tvalid = 1'b0;
            q += int'(m_if.tvalid);
            repeat (2) begin tick(); q += int'(m_if.tvalid); end
        end
        chk("saf_quiet", 128'(q), 128'd0);
        drive(mk(8'h3C, 3, 1'b1));
        tick();
        s_if.tvalid = 1'b0;
        chk("saf_k_tvalid", 128'(m_if.tvalid), 128'd0);
        q = 0;
        for (int j = 0; j < 4; j++) begin
            tick();
            if (m_if.tvalid && m_if.tuser === mk(8'h3C, j, j == 3).user) q++;
        end
        chk("saf_burst", 128'(q), 128'd4);
        tick();
        chk("saf_end_tvalid", 128'(m_if.tvalid), 128'd0);

        // Overflow: the output register pulls the first beat while stalled,
        // so the second packet hits full on its 6th beat and 59 beats remain stored.
        do_reset();
        m_if.tready = 1'b0;
        send_pkt(8'h60, 60, 0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            drive(mk(8'h61, i, i == 9));
            tick();
            if (i == 4) chk("ovf_b5_drop", 128'(drop_cnt), 128'd0);
            if (i == 5) chk("ovf_b6_drop", 128'(drop_cnt), 128'd1);
        end
        s_if.tvalid = 1'b0;
        tick();
        chk("ovf_drop", 128'(drop_cnt), 128'd1);
        chk("ovf_pkt", 128'(pkt_cnt), 128'd1);
        chk("ovf_fill", 128'(fill), 128'd59);
        m_if.tready = 1'b1;
        drain("ovf", 200);
        cmp_rx("ovf");

        // Oversize packet, then a small one.
        do_reset();
        send_pkt(8'h70, 70, 0, 1'b0);
        tick();
        chk("big_rx", 128'(rx.size()), 128'd0);
        chk("big_drop", 128'(drop_cnt), 128'd1);
        chk("big_pkt", 128'(pkt_cnt), 128'd0);
        send_pkt(8'h71, 2, 0, 1'b1);
        drain("big", 100);
        chk("big_pkt2", 128'(pkt_cnt), 128'd1);
        cmp_rx("big");

        // Backpressure toggling across many packets (wraps the buffer repeatedly).
        do_reset();
        stall_chk = 1'b1;
        toggle_en = 1'b1;
        for (int p = 0; p < 200; p++) send_pkt(8'(p), 3, 1, 1'b1);
        drain("bp", 3000);
        toggle_en = 1'b0;
        stall_chk = 1'b0;
        @(posedge clk); #2;
        m_if.tready = 1'b1;
        chk("bp_pkt", 128'(pkt_cnt), 128'd200);
        chk("bp_drop", 128'(drop_cnt), 128'd0);
        cmp_rx("bp");

        // Reset in the middle of a packet while the output is busy.
        do_reset();
        send_pkt(8'h80, 2, 0, 1'b0);
        drive(mk(8'h81, 0, 1'b0)); tick();
        drive(mk(8'h81, 1, 1'b0)); tick();
        drive(mk(8'h81, 2, 1'b0));
        rst = 1'b1;
        tick();
        s_if.tvalid = 1'b0;
        chk("mrst_tvalid", 128'(m_if.tvalid), 128'd0);
        chk("mrst_tdata", 128'(m_if.tdata[127:0]), 128'd0);
        chk("mrst_tuser", m_if.tuser, 128'd0);
        chk("mrst_tlast", 128'(m_if.tlast), 128'd0);
        chk("mrst_pkt", 128'(pkt_cnt), 128'd0);
        chk("mrst_fill", 128'(fill), 128'd0);
        chk("mrst_tready", 128'(s_if.tready), 128'd1);
        rst = 1'b0;
        rx.delete();
        exp_q.delete();
        drive(mk(8'h81, 3, 1'b0)); exp_q.push_back(mk(8'h81, 3, 1'b0)); tick();
        drive(mk(8'h81, 4, 1'b1)); exp_q.push_back(mk(8'h81, 4, 1'b1)); tick();
        s_if.tvalid = 1'b0;
        drain("mrst", 50);
        chk("mrst_pkt2", 128'(pkt_cnt), 128'd1);
        chk("mrst_drop", 128'(drop_cnt), 128'd0);
        cmp_rx("mrst");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
